// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port integer register file with a per-register busy
//                scoreboard, optional write-to-read bypass, optional
//                hardwired zero register and a stored-value debug read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NRD*$clog2(NREGS)-1:0]    rs_addr,
    output logic [NRD*XLEN-1:0]             rs_data,
    output logic [NRD-1:0]                  rs_busy,
    input  logic [NWR-1:0]                  wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]             wr_data,
    input  logic                            iss_en,
    input  logic [$clog2(NREGS)-1:0]        iss_rd,
    input  logic                            flush,
    input  logic [$clog2(NREGS)-1:0]        dbg_addr,
    output logic [XLEN-1:0]                 dbg_data
);

    localparam int AW = $clog2(NREGS);

    // Reject degenerate port counts at elaboration time.
    generate
        if (NRD < 1 || NWR < 1) begin : g_param_check
            $error("regfile_mp: NRD and NWR must both be at least 1");
        end
    endgenerate

    logic [NREGS-1:0][XLEN-1:0] r_regs;
    logic [NREGS-1:0][XLEN-1:0] w_regs_nxt;
    logic [NREGS-1:0]           r_busy;
    logic [NREGS-1:0]           w_busy_nxt;

    // True for the address of a hardwired-zero register.
    function automatic logic is_hardwired(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Next-state: flush first, then write clears (higher port overrides
    // lower on data), then issue set so a new producer owns the register.
    always_comb begin
        w_regs_nxt = r_regs;
        w_busy_nxt = flush ? '0 : r_busy;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && !is_hardwired(wr_addr[j*AW +: AW])) begin
                w_regs_nxt[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                w_busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en && !is_hardwired(iss_rd)) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
    end

    // Register array and scoreboard; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
            r_busy <= '0;
        end else begin
            r_regs <= w_regs_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    // Combinational read ports with optional same-cycle write bypass.
    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_data;
            logic            w_busy;

            assign w_addr = rs_addr[k*AW +: AW];

            // Stored value, overridden by the highest matching write port;
            // the zero register masks everything. Bypass is held off in
            // reset so outputs stay at zero.
            always_comb begin
                w_data = r_regs[w_addr];
                w_busy = r_busy[w_addr];
                if (BYPASS != 0 && rst_n) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_en[j] && (wr_addr[j*AW +: AW] == w_addr)) begin
                            w_data = wr_data[j*XLEN +: XLEN];
                            w_busy = 1'b0;
                        end
                    end
                end
                if (is_hardwired(w_addr)) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end
            end

            assign rs_data[k*XLEN +: XLEN] = w_data;
            assign rs_busy[k]              = w_busy;
        end
    endgenerate

    // Debug port sees only the committed contents.
    assign dbg_data = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp. Instance A uses NWR=2,
//                BYPASS=1, ZERO_REG=1; instance B uses NWR=1, BYPASS=0,
//                ZERO_REG=0. Both are compared with an array-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic [2*AW-1:0]   rs_addr_a;
    logic [2*XLEN-1:0] rs_data_a;
    logic [1:0]        rs_busy_a;
    logic [1:0]        wr_en_a;
    logic [2*AW-1:0]   wr_addr_a;
    logic [2*XLEN-1:0] wr_data_a;
    logic              iss_en_a;
    logic [AW-1:0]     iss_rd_a;
    logic              flush_a;
    logic [AW-1:0]     dbg_addr_a;
    logic [XLEN-1:0]   dbg_data_a;

    // Instance B signals
    logic [2*AW-1:0]   rs_addr_b;
    logic [2*XLEN-1:0] rs_data_b;
    logic [1:0]        rs_busy_b;
    logic [0:0]        wr_en_b;
    logic [AW-1:0]     wr_addr_b;
    logic [XLEN-1:0]   wr_data_b;
    logic              iss_en_b;
    logic [AW-1:0]     iss_rd_b;
    logic              flush_b;
    logic [AW-1:0]     dbg_addr_b;
    logic [XLEN-1:0]   dbg_data_b;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(rs_addr_a), .rs_data(rs_data_a), .rs_busy(rs_busy_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .iss_en(iss_en_a), .iss_rd(iss_rd_a), .flush(flush_a),
        .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(rs_addr_b), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .iss_en(iss_en_b), .iss_rd(iss_rd_b), .flush(flush_b),
        .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [XLEN-1:0] m_regs_a [32];
    bit              m_busy_a [32];
    logic [XLEN-1:0] m_regs_b [32];
    bit              m_busy_b [32];

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_regs_a[r] = '0; m_busy_a[r] = 1'b0;
            m_regs_b[r] = '0; m_busy_b[r] = 1'b0;
        end
    endtask

    // Apply one clock edge's worth of architectural effects.
    task automatic model_edge();
        if (flush_a) for (int r = 0; r < 32; r++) m_busy_a[r] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (wr_en_a[j] && wr_addr_a[j*AW +: AW] != 0) begin
                m_regs_a[wr_addr_a[j*AW +: AW]] = wr_data_a[j*XLEN +: XLEN];
                m_busy_a[wr_addr_a[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en_a && iss_rd_a != 0) m_busy_a[iss_rd_a] = 1'b1;

        if (flush_b) for (int r = 0; r < 32; r++) m_busy_b[r] = 1'b0;
        if (wr_en_b[0]) begin
            m_regs_b[wr_addr_b] = wr_data_b;
            m_busy_b[wr_addr_b] = 1'b0;
        end
        if (iss_en_b) m_busy_b[iss_rd_b] = 1'b1;
    endtask

    // Expected read value of instance A: zero reg, else latest enabled write, else stored.
    function automatic logic [XLEN-1:0] exp_data_a(input logic [AW-1:0] a);
        if (a == 0) return '0;
        for (int j = 1; j >= 0; j--)
            if (rst_n && wr_en_a[j] && wr_addr_a[j*AW +: AW] == a) return wr_data_a[j*XLEN +: XLEN];
        return m_regs_a[a];
    endfunction

    function automatic logic exp_busy_a(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        for (int j = 0; j < 2; j++)
            if (rst_n && wr_en_a[j] && wr_addr_a[j*AW +: AW] == a) return 1'b0;
        return m_busy_a[a];
    endfunction

    task automatic idle();
        wr_en_a = '0; iss_en_a = 1'b0; flush_a = 1'b0;
        wr_en_b = '0; iss_en_b = 1'b0; flush_b = 1'b0;
    endtask

    task automatic tick();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int r = 0; r < 32; r++) begin
            dbg_addr_a = AW'(r);
            rs_addr_a  = {AW'(r), AW'(r)};
            #1;
            tests++;
            if (dbg_data_a !== '0 || rs_data_a !== '0 || rs_busy_a !== 2'b00) begin
                fails++;
                $display("FAIL reset_state x%0d: dbg=%h rs=%h busy=%b, required all 0", r, dbg_data_a, rs_data_a, rs_busy_a);
            end
        end
        // Write x5 and mark x8 busy, then reset mid-cycle.
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd5}; wr_data_a = {32'h0, 32'hDEADBEEF};
        iss_en_a = 1'b1; iss_rd_a = 5'd8;
        tick();
        idle();
        rs_addr_a = {5'd8, 5'd5}; dbg_addr_a = 5'd5;
        #1;
        tests++;
        if (dbg_data_a !== 32'hDEADBEEF || rs_busy_a !== 2'b10) begin
            fails++;
            $display("FAIL pre_reset: dbg=%h busy=%b, required DEADBEEF 10", dbg_data_a, rs_busy_a);
        end
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd5}; wr_data_a = {32'h0, 32'h11111111};
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        tests++;
        if (rs_data_a[31:0] !== '0 || dbg_data_a !== '0 || rs_busy_a !== 2'b00) begin
            fails++;
            $display("FAIL async_reset: rs0=%h dbg=%h busy=%b, required 0 0 00", rs_data_a[31:0], dbg_data_a, rs_busy_a);
        end
        @(posedge clk);
        #1;
        tests++;
        if (dbg_data_a !== '0) begin
            fails++;
            $display("FAIL write_in_reset: dbg=%h, required 0", dbg_data_a);
        end
        idle();
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_bypass();
        iss_en_a = 1'b1; iss_rd_a = 5'd7;
        tick();
        idle();
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd7}; wr_data_a = {32'h0, 32'h12345678};
        rs_addr_a = {5'd7, 5'd7};
        wr_en_b = 1'b1; wr_addr_b = 5'd7; wr_data_b = 32'h12345678;
        rs_addr_b = {5'd0, 5'd7};
        #1;
        tests++;
        if (rs_data_a[31:0] !== 32'h12345678 || rs_busy_a[0] !== 1'b0) begin
            fails++;
            $display("FAIL bypass_on: data=%h busy=%b, required 12345678 0", rs_data_a[31:0], rs_busy_a[0]);
        end
        tests++;
        if (rs_data_b[31:0] !== 32'h0) begin
            fails++;
            $display("FAIL bypass_off: data=%h, required 0", rs_data_b[31:0]);
        end
        tick();
        idle();
        dbg_addr_a = 5'd7; dbg_addr_b = 5'd7;
        #1;
        tests++;
        if (dbg_data_a !== 32'h12345678 || dbg_data_b !== 32'h12345678 || rs_data_b[31:0] !== 32'h12345678) begin
            fails++;
            $display("FAIL bypass_commit: dbgA=%h dbgB=%h rsB=%h, required 12345678", dbg_data_a, dbg_data_b, rs_data_b[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd0}; wr_data_a = {32'h0, 32'hFFFFFFFF};
        iss_en_a = 1'b1; iss_rd_a = 5'd0;
        rs_addr_a = {5'd0, 5'd0};
        wr_en_b = 1'b1; wr_addr_b = 5'd0; wr_data_b = 32'hFFFFFFFF;
        #1;
        tests++;
        if (rs_data_a !== '0 || rs_busy_a !== 2'b00) begin
            fails++;
            $display("FAIL zero_bypass: data=%h busy=%b, required 0 00", rs_data_a, rs_busy_a);
        end
        tick();
        idle();
        dbg_addr_a = 5'd0; dbg_addr_b = 5'd0; rs_addr_b = {5'd0, 5'd0};
        #1;
        tests++;
        if (rs_data_a !== '0 || rs_busy_a !== 2'b00 || dbg_data_a !== '0) begin
            fails++;
            $display("FAIL zero_reg: rs=%h busy=%b dbg=%h, required 0", rs_data_a, rs_busy_a, dbg_data_a);
        end
        tests++;
        if (rs_data_b[31:0] !== 32'hFFFFFFFF || dbg_data_b !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL zero_ordinary: rs=%h dbg=%h, required FFFFFFFF", rs_data_b[31:0], dbg_data_b);
        end
    endtask

    task automatic test_scoreboard();
        iss_en_a = 1'b1; iss_rd_a = 5'd3;
        iss_en_b = 1'b1; iss_rd_b = 5'd3;
        tick();
        idle();
        rs_addr_a = {5'd0, 5'd3}; rs_addr_b = {5'd0, 5'd3};
        for (int c = 0; c < 2; c++) begin
            if (c == 1) begin
                wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd3}; wr_data_a = {32'h0, 32'h55};
                wr_en_b = 1'b1;  wr_addr_b = 5'd3;         wr_data_b = 32'h55;
            end
            #1;
            tests++;
            if (rs_busy_b[0] !== 1'b1 || rs_busy_a[0] !== (c == 0)) begin
                fails++;
                $display("FAIL busy_cycle%0d: A=%b B=%b, required A=%0d B=1", c, rs_busy_a[0], rs_busy_b[0], c == 0);
            end
            tick();
        end
        idle();
        #1;
        tests++;
        if (rs_busy_a[0] !== 1'b0 || rs_busy_b[0] !== 1'b0 || rs_data_a[31:0] !== 32'h55 || rs_data_b[31:0] !== 32'h55) begin
            fails++;
            $display("FAIL busy_cleared: A=%b/%h B=%b/%h, required 0/55", rs_busy_a[0], rs_data_a[31:0], rs_busy_b[0], rs_data_b[31:0]);
        end
        iss_en_a = 1'b1; iss_rd_a = 5'd3; wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd3}; wr_data_a = {32'h0, 32'h66};
        iss_en_b = 1'b1; iss_rd_b = 5'd3; wr_en_b = 1'b1;  wr_addr_b = 5'd3;         wr_data_b = 32'h66;
        tick();
        idle();
        #1;
        tests++;
        if (rs_busy_a[0] !== 1'b1 || rs_busy_b[0] !== 1'b1 || rs_data_a[31:0] !== 32'h66) begin
            fails++;
            $display("FAIL issue_wins: A=%b/%h B=%b, required 1/66 1", rs_busy_a[0], rs_data_a[31:0], rs_busy_b[0]);
        end
    endtask

    task automatic test_conflict();
        wr_en_a = 2'b11; wr_addr_a = {5'd9, 5'd9}; wr_data_a = {32'hB, 32'hA};
        rs_addr_a = {5'd9, 5'd9};
        #1;
        tests++;
        if (rs_data_a[63:32] !== 32'hB || rs_data_a[31:0] !== 32'hB) begin
            fails++;
            $display("FAIL conflict_bypass: rs=%h, required 0000000b0000000b", rs_data_a);
        end
        tick();
        idle();
        dbg_addr_a = 5'd9;
        #1;
        tests++;
        if (dbg_data_a !== 32'hB || rs_data_a[63:32] !== 32'hB) begin
            fails++;
            $display("FAIL conflict_commit: dbg=%h rs1=%h, required b", dbg_data_a, rs_data_a[63:32]);
        end
    endtask

    task automatic test_flush();
        wr_en_a = 2'b11; wr_addr_a = {5'd2, 5'd1}; wr_data_a = {32'h202, 32'h101};
        tick();
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd4}; wr_data_a = {32'h0, 32'h404};
        tick();
        idle();
        iss_en_a = 1'b1;
        iss_rd_a = 5'd1; tick();
        iss_rd_a = 5'd2; tick();
        iss_rd_a = 5'd4; tick();
        flush_a = 1'b1; iss_rd_a = 5'd6;
        tick();
        idle();
        for (int r = 0; r < 32; r++) begin
            rs_addr_a = {AW'(r), AW'(r)};
            #1;
            tests++;
            if (rs_busy_a !== {2{r == 6}}) begin
                fails++;
                $display("FAIL flush_busy x%0d: busy=%b, required %0d", r, rs_busy_a, r == 6);
            end
        end
        dbg_addr_a = 5'd1; rs_addr_a = {5'd4, 5'd2};
        #1;
        tests++;
        if (dbg_data_a !== 32'h101 || rs_data_a !== {32'h404, 32'h202}) begin
            fails++;
            $display("FAIL flush_contents: x1=%h x2=%h x4=%h, required 101 202 404", dbg_data_a, rs_data_a[31:0], rs_data_a[63:32]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en_a   = 2'($urandom);
            wr_addr_a = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_data_a = {$urandom, $urandom};
            iss_en_a  = 1'($urandom);
            iss_rd_a  = 5'($urandom_range(0, 7));
            flush_a   = ($urandom_range(0, 15) == 0);
            rs_addr_a = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            dbg_addr_a = 5'($urandom_range(0, 7));
            wr_en_b   = 1'($urandom);
            wr_addr_b = 5'($urandom_range(0, 7));
            wr_data_b = $urandom;
            iss_en_b  = 1'($urandom);
            iss_rd_b  = 5'($urandom_range(0, 7));
            flush_b   = ($urandom_range(0, 15) == 0);
            rs_addr_b = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            dbg_addr_b = 5'($urandom_range(0, 7));
            #1;
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (rs_data_a[k*XLEN +: XLEN] !== exp_data_a(rs_addr_a[k*AW +: AW]) ||
                    rs_busy_a[k] !== exp_busy_a(rs_addr_a[k*AW +: AW])) begin
                    fails++;
                    $display("FAIL rand_a_port%0d cyc%0d: data=%h busy=%b, required %h %b", k, c,
                             rs_data_a[k*XLEN +: XLEN], rs_busy_a[k],
                             exp_data_a(rs_addr_a[k*AW +: AW]), exp_busy_a(rs_addr_a[k*AW +: AW]));
                end
                tests++;
                if (rs_data_b[k*XLEN +: XLEN] !== m_regs_b[rs_addr_b[k*AW +: AW]] ||
                    rs_busy_b[k] !== m_busy_b[rs_addr_b[k*AW +: AW]]) begin
                    fails++;
                    $display("FAIL rand_b_port%0d cyc%0d: data=%h busy=%b, required %h %b", k, c,
                             rs_data_b[k*XLEN +: XLEN], rs_busy_b[k],
                             m_regs_b[rs_addr_b[k*AW +: AW]], m_busy_b[rs_addr_b[k*AW +: AW]]);
                end
            end
            tests++;
            if (dbg_data_a !== m_regs_a[dbg_addr_a] || dbg_data_b !== m_regs_b[dbg_addr_b]) begin
                fails++;
                $display("FAIL rand_dbg cyc%0d: A=%h B=%h, required %h %h", c,
                         dbg_data_a, dbg_data_b, m_regs_a[dbg_addr_a], m_regs_b[dbg_addr_b]);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        rs_addr_a = '0; wr_addr_a = '0; wr_data_a = '0; iss_rd_a = '0; dbg_addr_a = '0;
        rs_addr_b = '0; wr_addr_b = '0; wr_data_b = '0; iss_rd_b = '0; dbg_addr_b = '0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_conflict();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
